// File: rtl/proc_mc_pkg.sv
// rtl/proc_mc_pkg.sv - opcodes, FSM states and instruction field positions for proc_mc
package proc_mc_pkg;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_MVNZ = 4'd8;
  localparam logic [3:0] OP_LD   = 4'd9;
  localparam logic [3:0] OP_SD   = 4'd10;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int A_MSB   = 11;
  localparam int A_LSB   = 9;
  localparam int B_MSB   = 8;
  localparam int B_LSB   = 6;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WB    = 2'd2
  } state_t;

endpackage

// File: rtl/proc_mc_if.sv
// rtl/proc_mc_if.sv - harness-facing run/load/retire signals of proc_mc
interface proc_mc_if #(
  parameter int DATA_W  = 16,
  parameter int IMEM_AW = 4
);
  logic               Run;
  logic               Load;
  logic [IMEM_AW-1:0] LoadAddr;
  logic [15:0]        DIN;
  logic               Done;
  logic [DATA_W-1:0]  Out;
  logic [IMEM_AW-1:0] PC;

  modport master (output Run, Load, LoadAddr, DIN, input Done, Out, PC);
  modport slave  (input Run, Load, LoadAddr, DIN, output Done, Out, PC);
endinterface

// File: rtl/proc_mc_alu.sv
// rtl/proc_mc_alu.sv - combinational ALU for proc_mc; sll/srl exist only under PROC_MC_SHIFT_EN
module proc_mc_alu
  import proc_mc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

`ifdef PROC_MC_SHIFT_EN
  localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);
`endif

  always_comb begin
    y = '0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_AND: y = a & b;
      OP_SLT: y = DATA_W'(a < b);
`ifdef PROC_MC_SHIFT_EN
      // The whole of b is the shift amount, so oversized shifts clear the word.
      OP_SLL: y = (b >= SHIFT_LIM) ? '0 : (a << b);
      OP_SRL: y = (b >= SHIFT_LIM) ? '0 : (a >> b);
`endif
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/proc_mc.sv
// rtl/proc_mc.sv - multi-cycle 16-bit-instruction processor; PROC_MC_SHIFT_EN enables sll/srl
module proc_mc
  import proc_mc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int IMEM_AW = 4,
  parameter int DMEM_AW = 3
) (
  input  logic     Clock,
  input  logic     Reset,
  proc_mc_if.slave bus
);

  localparam logic [IMEM_AW-1:0] PC_STEP = IMEM_AW'(1);

  logic [15:0]        imem [2**IMEM_AW];
  logic [DATA_W-1:0]  dmem [2**DMEM_AW];
  logic [DATA_W-1:0]  regs [8];

  state_t             state;
  logic [15:0]        ir;
  logic [IMEM_AW-1:0] pc;
  logic [DATA_W-1:0]  res_q;
  logic               done_q;
  logic [DATA_W-1:0]  out_q;

  logic [3:0]         opcode;
  logic [2:0]         a_idx;
  logic [2:0]         b_idx;
  logic [DATA_W-1:0]  ra;
  logic [DATA_W-1:0]  rb;
  logic [DATA_W-1:0]  imm_val;
  logic [DATA_W-1:0]  alu_y;
  logic [DMEM_AW-1:0] daddr;

  assign opcode  = ir[OPC_MSB:OPC_LSB];
  assign a_idx   = ir[A_MSB:A_LSB];
  assign b_idx   = ir[B_MSB:B_LSB];
  assign ra      = regs[a_idx];
  assign rb      = regs[b_idx];
  assign imm_val = DATA_W'({ir[B_MSB:B_LSB], ir[IMM_MSB:IMM_LSB]});
  assign daddr   = rb[DMEM_AW-1:0];

  assign bus.Done = done_q;
  assign bus.Out  = out_q;
  assign bus.PC   = pc;

  proc_mc_alu #(.DATA_W(DATA_W)) u_alu (
    .op (opcode),
    .a  (ra),
    .b  (rb),
    .y  (alu_y)
  );

  // Memories are never reset; writes are suppressed while Reset is high.
  always_ff @(posedge Clock) begin
    if (!Reset && state == FETCH && !bus.Run && bus.Load)
      imem[bus.LoadAddr] <= bus.DIN;
  end

  always_ff @(posedge Clock) begin
    if (!Reset && state == EXEC && opcode == OP_SD)
      dmem[daddr] <= ra;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= FETCH;
      pc     <= '0;
      ir     <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
      out_q  <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        FETCH: begin
          if (bus.Run) begin
            ir    <= imem[pc];
            pc    <= pc + PC_STEP;
            state <= EXEC;
          end
        end
        EXEC: begin
          state  <= FETCH;
          done_q <= 1'b1;
          case (opcode)
            OP_MV: begin
              regs[a_idx] <= rb;
              out_q       <= rb;
            end
            OP_MVI: begin
              regs[a_idx] <= imm_val;
              out_q       <= imm_val;
            end
            OP_ADD, OP_SUB: begin
              res_q  <= alu_y;
              state  <= WB;
              done_q <= 1'b0;
            end
            OP_LD: begin
              res_q  <= dmem[daddr];
              state  <= WB;
              done_q <= 1'b0;
            end
`ifdef PROC_MC_SHIFT_EN
            OP_AND, OP_SLT, OP_SLL, OP_SRL: begin
`else
            OP_AND, OP_SLT: begin
`endif
              regs[a_idx] <= alu_y;
              out_q       <= alu_y;
            end
            OP_MVNZ: begin
              out_q <= ra;
              if (rb != '0) pc <= ra[IMEM_AW-1:0];
            end
            OP_SD: out_q <= ra;
            default: ;
          endcase
        end
        WB: begin
          regs[a_idx] <= res_q;
          out_q       <= res_q;
          done_q      <= 1'b1;
          state       <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_mc.sv
// tb/tb_proc_mc.sv - self-checking bench for proc_mc against an instruction-level model
module tb_proc_mc;
  import proc_mc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  proc_mc_if #(.DATA_W(16), .IMEM_AW(4)) bus ();

  proc_mc #(.DATA_W(16), .IMEM_AW(4), .DMEM_AW(3)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction-set model state
  logic [15:0] imem_m [16];
  logic [15:0] dmem_m [8];
  logic [15:0] regs_m [8];
  logic [3:0]  pc_m;
  logic [15:0] out_m;
  logic [3:0]  ld_ptr;

  function automatic logic [15:0] mvi(input int r, input int v);
    return {OP_MVI, 3'(r), 9'(v)};
  endfunction

  function automatic logic [15:0] ins(input logic [3:0] op, input int a, input int b);
    return {op, 3'(a), 3'(b), 6'd0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) regs_m[i] = 16'd0;
    pc_m  = 4'd0;
    out_m = 16'd0;
  endtask

  task automatic model_step(output int lat);
    logic [15:0] w, ra, rb, v;
    int a, b;
    w = imem_m[pc_m];
    pc_m = pc_m + 4'd1;
    a = int'(w[11:9]);
    b = int'(w[8:6]);
    ra = regs_m[a];
    rb = regs_m[b];
    lat = 2;
    case (w[15:12])
      OP_MV:   begin regs_m[a] = rb; out_m = rb; end
      OP_MVI:  begin v = {7'd0, w[8:0]}; regs_m[a] = v; out_m = v; end
      OP_ADD:  begin v = ra + rb; regs_m[a] = v; out_m = v; lat = 3; end
      OP_SUB:  begin v = ra - rb; regs_m[a] = v; out_m = v; lat = 3; end
      OP_AND:  begin v = ra & rb; regs_m[a] = v; out_m = v; end
      OP_SLT:  begin v = (ra < rb) ? 16'd1 : 16'd0; regs_m[a] = v; out_m = v; end
      OP_SLL, OP_SRL: begin
`ifdef PROC_MC_SHIFT_EN
        if (rb >= 16'd16) v = 16'd0;
        else if (w[15:12] == OP_SLL) v = ra << rb;
        else v = ra >> rb;
        regs_m[a] = v;
        out_m = v;
`endif
      end
      OP_MVNZ: begin out_m = ra; if (rb != 16'd0) pc_m = ra[3:0]; end
      OP_LD:   begin v = dmem_m[rb[2:0]]; regs_m[a] = v; out_m = v; lat = 3; end
      OP_SD:   begin dmem_m[rb[2:0]] = ra; out_m = ra; end
      default: ;
    endcase
  endtask

  task automatic put(input logic [15:0] w);
    bus.Load = 1'b1;
    bus.LoadAddr = ld_ptr;
    bus.DIN = w;
    @(posedge clk); @(negedge clk);
    bus.Load = 1'b0;
    imem_m[ld_ptr] = w;
    ld_ptr = ld_ptr + 4'd1;
    checks++;
    if (bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL done_while_idle: got %b expected 0", bus.Done);
    end
  endtask

  task automatic exec_n(input int n, input bit noise);
    int cnt, lat;
    bus.Run = 1'b1;
    for (int k = 0; k < n; k++) begin
      model_step(lat);
      cnt = 0;
      do begin
        if (noise) begin
          bus.Load = 1'b1;
          bus.LoadAddr = 4'($urandom_range(15, 0));
          bus.DIN = 16'($urandom);
        end
        @(posedge clk); @(negedge clk);
        cnt++;
      end while (bus.Done !== 1'b1 && cnt < 8);
      checks++;
      if (cnt != lat) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d cycles expected %0d", k, cnt, lat);
      end
      checks++;
      if (bus.Out !== out_m) begin
        errors++;
        $display("FAIL out[%0d]: got %h expected %h", k, bus.Out, out_m);
      end
      checks++;
      if (bus.PC !== pc_m) begin
        errors++;
        $display("FAIL pc[%0d]: got %0d expected %0d", k, bus.PC, pc_m);
      end
    end
    bus.Run = 1'b0;
    bus.Load = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got %b expected 0", bus.Done);
    end
  endtask

  task automatic step_pulse();
    int cnt, lat;
    model_step(lat);
    bus.Run = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.Run = 1'b0;
    cnt = 1;
    while (bus.Done !== 1'b1 && cnt < 8) begin
      @(posedge clk); @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt != lat) begin
      errors++;
      $display("FAIL pulse_latency: got %0d cycles expected %0d", cnt, lat);
    end
    checks++;
    if (bus.Out !== out_m) begin
      errors++;
      $display("FAIL pulse_out: got %h expected %h", bus.Out, out_m);
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Run = 1'b0;
    bus.Load = 1'b0;
    bus.LoadAddr = 4'd0;
    bus.DIN = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_done", {15'd0, bus.Done}, 16'd0);
    check_val("reset_out", bus.Out, 16'd0);
    check_val("reset_pc", {12'd0, bus.PC}, 16'd0);
    rst = 1'b0;
    model_reset();
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check_val("idle_pc", {12'd0, bus.PC}, 16'd0);
    check_val("idle_done", {15'd0, bus.Done}, 16'd0);
  endtask

  task automatic test_basic();
    ld_ptr = pc_m;
    put(mvi(3, 3));
    put(mvi(2, 5));
    put(ins(OP_ADD, 2, 3));
    exec_n(3, 1'b0);
    check_val("add_out", bus.Out, 16'd8);
  endtask

  task automatic test_sub();
    ld_ptr = pc_m;
    put(mvi(4, 1));
    put(ins(OP_SUB, 4, 3));
    exec_n(2, 1'b0);
    check_val("sub_wrap", bus.Out, 16'hFFFE);
  endtask

  task automatic test_mvnz();
    ld_ptr = pc_m;
    put(mvi(1, 9));
    put(mvi(2, 1));
    put(ins(OP_MVNZ, 1, 2));
    exec_n(3, 1'b0);
    check_val("mvnz_taken_pc", {12'd0, bus.PC}, 16'd9);
    check_val("mvnz_out", bus.Out, 16'd9);
    ld_ptr = pc_m;
    put(mvi(2, 0));
    put(ins(OP_MVNZ, 1, 2));
    exec_n(2, 1'b0);
    check_val("mvnz_not_taken_pc", {12'd0, bus.PC}, 16'd11);
  endtask

  task automatic test_ld_sd();
    ld_ptr = pc_m;
    put(mvi(3, 7));
    put(mvi(1, 2));
    put(ins(OP_SD, 3, 1));
    put(ins(OP_LD, 5, 1));
    exec_n(4, 1'b0);
    check_val("ld_after_sd", bus.Out, 16'd7);
    ld_ptr = pc_m;
    put(mvi(1, 10));
    put(mvi(3, 11));
    put(ins(OP_SD, 3, 1));
    put(mvi(1, 2));
    put(ins(OP_LD, 5, 1));
    exec_n(5, 1'b0);
    check_val("daddr_truncate", bus.Out, 16'd11);
  endtask

  task automatic test_wrap();
    ld_ptr = pc_m;
    put(mvi(1, 15));
    put(mvi(2, 1));
    put(ins(OP_MVNZ, 1, 2));
    exec_n(3, 1'b0);
    check_val("wrap_at_15", {12'd0, bus.PC}, 16'd15);
    ld_ptr = 4'd15;
    put(mvi(0, 33));
    step_pulse();
    check_val("wrap_pc", {12'd0, bus.PC}, 16'd0);
    check_val("wrap_out", bus.Out, 16'd33);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check_val("hold_pc", {12'd0, bus.PC}, 16'd0);
    check_val("hold_done", {15'd0, bus.Done}, 16'd0);
  endtask

  task automatic test_shift();
    ld_ptr = pc_m;
    put(mvi(1, 1));
    put(mvi(2, 4));
    put(ins(OP_SLL, 1, 2));
    exec_n(3, 1'b0);
`ifdef PROC_MC_SHIFT_EN
    check_val("sll_out", bus.Out, 16'd16);
`else
    check_val("sll_noop_out", bus.Out, 16'd4);
`endif
    ld_ptr = pc_m;
    put(ins(OP_MV, 6, 1));
    put(mvi(2, 3));
    put(ins(OP_SRL, 1, 2));
    put(mvi(2, 16));
    put(ins(OP_SLL, 1, 2));
    put(ins(OP_MV, 6, 1));
    exec_n(6, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 8; a++) begin
      ld_ptr = pc_m;
      put(mvi(0, int'($urandom_range(511, 0))));
      put(mvi(1, a));
      put(ins(OP_SD, 0, 1));
      exec_n(3, 1'b0);
    end
    for (int r = 0; r < 3; r++) begin
      ld_ptr = pc_m;
      for (int i = 0; i < 16; i++) put(16'($urandom));
      exec_n(50, 1'b1);
    end
  endtask

  task automatic test_reset_abort();
    ld_ptr = pc_m;
    put(mvi(2, 5));
    put(mvi(3, 3));
    put(ins(OP_ADD, 2, 3));
    exec_n(2, 1'b0);
    bus.Run = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    bus.Run = 1'b0;
    @(posedge clk); @(negedge clk);
    check_val("abort_done", {15'd0, bus.Done}, 16'd0);
    check_val("abort_out", bus.Out, 16'd0);
    check_val("abort_pc", {12'd0, bus.PC}, 16'd0);
    rst = 1'b0;
    model_reset();
    ld_ptr = 4'd0;
    put(ins(OP_MV, 7, 2));
    put(mvi(1, 2));
    put(ins(OP_LD, 5, 1));
    exec_n(3, 1'b0);
    check_val("dmem_kept", bus.Out, dmem_m[2]);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sub();
    test_mvnz();
    test_ld_sd();
    test_wrap();
    test_shift();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
